coherence_bus_ctrl: RTL
=======================

// Module: coherence_bus_ctrl
// PURPOSE
// - Memory-side responder for the two data caches' coherent bus: arbitrates dREN/dWEN/cctrans requests from cache 0/1.
// - Snoops the peer cache (ccwait/ccsnoopaddr/ccinv) and serves the requester cache-to-cache or from RAM.
// - Drives a single word-wide RAM port; cache writebacks/flushes go straight to RAM.
// PARAMETERS
// - NCACHE   2        number of data caches (fixed at 2; peer of cache i is cache ~i)
// - ADDR_W   32       address/data word width (word_t)
// PORTS
// - CLK          in   1         clock, rising edge; one clock domain
// - nRST         in   1         reset, asynchronous, active low
// - dREN         in   [1:0]     per-cache block-load request
// - dWEN         in   [1:0]     per-cache store (writeback, flush, snoop writeback)
// - daddr        in   [1:0][31:0]  per-cache word address (bit 2 = block word)
// - dstore       in   [1:0][31:0]  per-cache store data
// - cctrans      in   [1:0]     coherent transaction / snoop acknowledge
// - ccwrite      in   [1:0]     requester: intent to modify; snooper: holds dirty copy
// - dwait        out  [1:0]     1 = stall; 0 for exactly one cycle completes a word
// - dload        out  [1:0][31:0]  load data, valid when dwait[i]==0
// - ccwait       out  [1:0]     1 = cache i is being snooped
// - ccinv        out  [1:0]     1 = cache i invalidates snooped block
// - ccsnoopaddr  out  [1:0][31:0]  snoop address presented to cache i
// - ramREN/ramWEN out 1         RAM read/write strobes
// - ramaddr      out  32        RAM address;  ramstore out 32 RAM write data
// - ramload      in   32        RAM read data;  ramstate in 2 ramstate_t {FREE,BUSY,ACCESS,ERROR}
// BEHAVIOUR
// - Reset: state=IDLE, rr pointer=0; dwait=2'b11, all other outputs 0; reset mid-transfer aborts it, no RAM strobe held.
// - RAM word completes only when ramstate==ACCESS; BUSY/FREE/ERROR = keep waiting, strobes held stable.
// - IDLE: pick a cache with dREN|dWEN; both pending -> grant rr pointer cache; pointer flips to loser on every grant.
//   granted dWEN & !cctrans-read (writeback/flush) -> WB; granted dREN & cctrans -> SNOOP.
// - WB: ramWEN=1, ramaddr/ramstore=granted daddr/dstore; on ACCESS dwait[g]=0 one cycle; return IDLE when dWEN[g] drops
//   (2-word writebacks are two back-to-back WB completions; no re-arbitration while dWEN[g] held).
// - SNOOP (requester r, snooper s): ccwait[s]=1, ccsnoopaddr[s]=daddr[r], ccinv[s]=ccwrite[r]; dwait[r]=1.
//   Next when cctrans[s]=1: ccwrite[s]=1 -> C2C1, else -> RAM1. Stays in SNOOP until snooper acknowledges.
// - C2C1/C2C2: snooper drives dWEN[s]; ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s]; dload[r]=dstore[s];
//   on ACCESS: dwait[s]=0 and dwait[r]=0 same cycle; C2C1->C2C2->IDLE. ccwait[s] held 1 throughout.
// - RAM1/RAM2: ramREN=1, ramaddr=daddr[r]; dload[r]=ramload; on ACCESS dwait[r]=0; RAM1->RAM2->IDLE; ccwait[s] held.
// - Leaving to IDLE drops ccwait/ccinv same edge; non-granted cache's dwait stays 1 for the whole transaction.
// - ramREN and ramWEN never both 1. A cache never receives ccwait while it is granted.
// CONFIGURATION
// - BUS_STATS_EN defined: adds outputs c2c_count[31:0], ramld_count[31:0]; +1 on each C2C2 / RAM2 completion,
//   reset to 0, wrap at 2^32. Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
// - coherence_pkg: bus_state_t {IDLE,WB,SNOOP,C2C1,C2C2,RAM1,RAM2}; reuse word_t, ramstate_t from cpu_types_pkg.
// - Sub-module bus_rr_arbiter: 2-requester round-robin, inputs req[1:0]/advance, outputs grant index, pointer register.
// - Top: state register + granted index register, next-state comb, output comb muxed by requester/snooper index.
// TESTING
// - Cache0 dREN+cctrans @0x100, cache1 acks cctrans=1 ccwrite=0 -> ccwait[1]=1, ccsnoopaddr[1]=0x100; RAM reads 0x100,0x104; dwait[0] low twice.
// - Same, cache0 ccwrite=1, cache1 dirty (ccwrite=1, dWEN, dstore=0xAA,0xBB) -> ccinv[1]=1; dload[0]=0xAA then 0xBB; RAM written both.
// - Cache1 writeback dWEN @0x208 data 0x55, no cctrans -> ramWEN=1 ramaddr=0x208; no ccwait to cache0.
// - Both caches dREN+cctrans same cycle after reset -> cache0 served first, then cache1; third tie grants cache0 again only after cache1.
// - ramstate=BUSY 5 cycles in RAM1 -> dwait[r] held 1, ramREN/ramaddr stable; completes on ACCESS.
// - nRST low during C2C1 -> all outputs at reset values immediately; next request starts clean from IDLE.

Source files
------------

// File: rtl/coherence_pkg.sv
// Coherent bus controller state encoding and small index helper.
package coherence_pkg;
    typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C1, C2C2, RAM1, RAM2} bus_state_t;

    function automatic logic peer_of(input logic idx);
        return ~idx;
    endfunction
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus word and RAM handshake state.
package cpu_types_pkg;
    parameter int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/bus_rr_arbiter.sv
// Two-requester round-robin arbiter; the pointer moves to the loser on each grant.
module bus_rr_arbiter (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant
);
    logic ptr;

    always_comb begin
        grant = 1'b0;
        case (req)
            2'b11:   grant = ptr;
            2'b10:   grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            ptr <= 1'b0;
        else if (advance)
            ptr <= ~grant;
    end
endmodule

// File: rtl/coherence_bus_ctrl.sv
// Memory-side responder for two coherent data caches: arbitration, snooping, C2C/RAM service.
// Optional BUS_STATS_EN adds completion counters c2c_count / ramld_count.
module coherence_bus_ctrl
    import coherence_pkg::*;
    import cpu_types_pkg::*;
#(
    parameter int NCACHE = 2,
    parameter int ADDR_W = 32
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic [NCACHE-1:0]              dREN,
    input  logic [NCACHE-1:0]              dWEN,
    input  logic [NCACHE-1:0][ADDR_W-1:0]  daddr,
    input  logic [NCACHE-1:0][ADDR_W-1:0]  dstore,
    input  logic [NCACHE-1:0]              cctrans,
    input  logic [NCACHE-1:0]              ccwrite,
    output logic [NCACHE-1:0]              dwait,
    output logic [NCACHE-1:0][ADDR_W-1:0]  dload,
    output logic [NCACHE-1:0]              ccwait,
    output logic [NCACHE-1:0]              ccinv,
    output logic [NCACHE-1:0][ADDR_W-1:0]  ccsnoopaddr,
    output logic                           ramREN,
    output logic                           ramWEN,
    output logic [ADDR_W-1:0]              ramaddr,
    output logic [ADDR_W-1:0]              ramstore,
    input  logic [ADDR_W-1:0]              ramload,
    input  ramstate_t                      ramstate
`ifdef BUS_STATS_EN
    ,
    output word_t                          c2c_count,
    output word_t                          ramld_count
`endif
);
    bus_state_t state, state_nxt;
    logic       gnt;
    logic       arb_gnt;
    logic       arb_adv;
    logic       r;
    logic       s;
    logic       ram_done;

    assign r        = gnt;
    assign s        = peer_of(gnt);
    assign ram_done = (ramstate == ACCESS);

    bus_rr_arbiter u_arb (
        .CLK     (CLK),
        .nRST    (nRST),
        .req     (dREN | dWEN),
        .advance (arb_adv),
        .grant   (arb_gnt)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            gnt   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)
                gnt <= arb_gnt;
        end
    end

    always_comb begin
        state_nxt = state;
        arb_adv   = 1'b0;
        case (state)
            IDLE: begin
                if (|(dREN | dWEN)) begin
                    arb_adv = 1'b1;
                    // A store that is not also a coherent read is a writeback/flush
                    if (dWEN[arb_gnt] && !(dREN[arb_gnt] && cctrans[arb_gnt]))
                        state_nxt = WB;
                    else
                        state_nxt = SNOOP;
                end
            end
            WB:    if (!dWEN[r]) state_nxt = IDLE;
            SNOOP: if (cctrans[s]) state_nxt = ccwrite[s] ? C2C1 : RAM1;
            C2C1:  if (ram_done) state_nxt = C2C2;
            C2C2:  if (ram_done) state_nxt = IDLE;
            RAM1:  if (ram_done) state_nxt = RAM2;
            RAM2:  if (ram_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            WB: begin
                // Strobe follows dWEN so the release cycle issues no stray write
                ramWEN   = dWEN[r];
                ramaddr  = daddr[r];
                ramstore = dstore[r];
                dwait[r] = !(ram_done && dWEN[r]);
            end
            SNOOP, C2C1, C2C2, RAM1, RAM2: begin
                ccwait[s]      = 1'b1;
                ccsnoopaddr[s] = daddr[r];
                ccinv[s]       = ccwrite[r];
                if (state == C2C1 || state == C2C2) begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[s];
                    ramstore = dstore[s];
                    dload[r] = dstore[s];
                    if (ram_done) begin
                        dwait[s] = 1'b0;
                        dwait[r] = 1'b0;
                    end
                end else if (state == RAM1 || state == RAM2) begin
                    ramREN   = 1'b1;
                    ramaddr  = daddr[r];
                    dload[r] = ramload;
                    if (ram_done)
                        dwait[r] = 1'b0;
                end
            end
            default: ;
        endcase
    end

`ifdef BUS_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            c2c_count   <= '0;
            ramld_count <= '0;
        end else begin
            if (state == C2C2 && ram_done)
                c2c_count <= c2c_count + 32'd1;
            if (state == RAM2 && ram_done)
                ramld_count <= ramld_count + 32'd1;
        end
    end
`endif
endmodule
